// File: rtl/axi_frame_tx_pkg.sv
// Shared types and constants for the axi_frame_tx command-driven frame generator.
package axi_frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int unsigned FRAME_CNT_WIDTH = 16;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LEN_WIDTH  = 12;

    // cmd_tdata layout for the default widths: {len_m1, seed}
    localparam int unsigned LEN_LSB = DEF_DATA_WIDTH;
    localparam int unsigned LEN_MSB = DEF_DATA_WIDTH + DEF_LEN_WIDTH - 1;

endpackage

// File: rtl/axi_frame_tx.sv
// AXI-Stream frame transmitter: one incrementing-pattern frame per command, launch gated by fifo_almost_full.
// Optional macro AXI_FRAME_TX_MIDFRAME_THROTTLE_EN also gates each non-last word on fifo_almost_full.
module axi_frame_tx
    import axi_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                            clk,
    input  logic                            async_reset_n,
    input  logic                            cmd_tvalid,
    input  logic [LEN_WIDTH+DATA_WIDTH-1:0] cmd_tdata,
    output logic                            cmd_tready,
    input  logic                            fifo_almost_full,
    output logic                            m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic [FRAME_CNT_WIDTH-1:0]      frame_cnt
);

    localparam int unsigned CMD_LEN_LSB = DATA_WIDTH;

    state_e                       state_q, state_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d;
    logic [DATA_WIDTH-1:0]        seed_q, seed_d;
    logic [LEN_WIDTH-1:0]         k_q, k_d;
    logic [LEN_WIDTH-1:0]         k_next;
    logic [DATA_WIDTH-1:0]        tdata_q, tdata_d;
    logic                         tvalid_q, tvalid_d;
    logic                         tlast_q, tlast_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic [FRAME_CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            seed_q      <= '0;
            k_q         <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            k_q         <= k_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            cmd_ready_q <= cmd_ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        seed_d      = seed_q;
        k_d         = k_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        frame_cnt_d = frame_cnt_q;
        k_next      = k_q + LEN_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (cmd_tvalid && cmd_ready_q) begin
                    len_d   = cmd_tdata[CMD_LEN_LSB +: LEN_WIDTH];
                    seed_d  = cmd_tdata[DATA_WIDTH-1:0];
                    k_d     = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!fifo_almost_full) begin
                    tdata_d  = seed_q;
                    tvalid_d = 1'b1;
                    tlast_d  = (len_q == '0);
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                        state_d     = IDLE;
                    end else begin
                        k_d     = k_next;
                        tdata_d = seed_q + DATA_WIDTH'(k_next);
                        tlast_d = (k_next == len_q);
`ifdef AXI_FRAME_TX_MIDFRAME_THROTTLE_EN
                        tvalid_d = !fifo_almost_full;
`endif
                    end
                end
`ifdef AXI_FRAME_TX_MIDFRAME_THROTTLE_EN
                // Throttled word is already loaded in tdata_q; just re-present it.
                else if (!tvalid_q && !fifo_almost_full) begin
                    tvalid_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_tready    = cmd_ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != IDLE);
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axi_frame_tx.sv
// Directed self-checking bench for axi_frame_tx (default widths 32/12).
module tb_axi_frame_tx;

    logic        clk;
    logic        async_reset_n;
    logic        cmd_tvalid;
    logic [43:0] cmd_tdata;
    logic        cmd_tready;
    logic        fifo_almost_full;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    logic [31:0] got[$];
    int          got_lasts;
    int          got_unstable;
    int          got_first_c;
    int          got_last_c;

    axi_frame_tx #(.DATA_WIDTH(32), .LEN_WIDTH(12)) dut (
        .clk              (clk),
        .async_reset_n    (async_reset_n),
        .cmd_tvalid       (cmd_tvalid),
        .cmd_tdata        (cmd_tdata),
        .cmd_tready       (cmd_tready),
        .fifo_almost_full (fifo_almost_full),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .busy             (busy),
        .frame_cnt        (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a command and returns at the negedge right after the handshake edge.
    task automatic send_cmd(input logic [11:0] len_m1, input logic [31:0] seed);
        int n = 0;
        @(negedge clk);
        while (!cmd_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!cmd_tready) begin
            bad++;
            $display("FAIL cmd_accept_timeout got cmd_tready=%0b want 1", cmd_tready);
        end
        cmd_tvalid = 1'b1;
        cmd_tdata  = {len_m1, seed};
        @(negedge clk);
        cmd_tvalid = 1'b0;
    endtask

    // Collects words until a tlast handshake; returns at the negedge before that final edge.
    task automatic recv_frame(input bit rand_rdy, input int budget);
        bit          stalled = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        got = {};
        got_lasts = 0;
        got_unstable = 0;
        got_first_c = -1;
        got_last_c = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (stalled && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
                got_unstable++;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (got_first_c < 0) got_first_c = c;
                got.push_back(m_axis_tdata);
                if (m_axis_tlast) begin
                    got_lasts++;
                    got_last_c = c;
                    break;
                end
            end
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic check_pattern(input string name, input logic [31:0] seed, input int n);
        logic [31:0] e;
        total++;
        if (got.size() !== n) begin
            bad++;
            $display("FAIL %s_len got %0d want %0d", name, got.size(), n);
        end
        total++;
        if (got_lasts !== 1) begin
            bad++;
            $display("FAIL %s_tlast got %0d want 1", name, got_lasts);
        end
        for (int i = 0; i < got.size() && i < n; i++) begin
            e = seed + 32'(i);
            total++;
            if (got[i] !== e) begin
                bad++;
                $display("FAIL %s_word[%0d] got %h want %h", name, i, got[i], e);
            end
        end
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk);
        total++;
        if (frame_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL %s_frame_cnt got %0d want %0d", name, frame_cnt, exp_cnt);
        end
        total++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle got busy=%0b tvalid=%0b want 0 0", name, busy, m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        async_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, frame_cnt} !== 52'd0) begin
            bad++;
            $display("FAIL reset_values got rdy=%0b v=%0b d=%h l=%0b b=%0b cnt=%0d want all 0",
                     cmd_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, frame_cnt);
        end
        async_reset_n = 1'b1;
        #1;
        total++;
        if (cmd_tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_rdy got %0b want 0", cmd_tready);
        end
        @(negedge clk);
        total++;
        if (cmd_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_edge_rdy got %0b want 1", cmd_tready);
        end
    endtask

    task automatic test_basic_frame();
        send_cmd(12'd3, 32'h10);
        total++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || cmd_tready !== 1'b0) begin
            bad++;
            $display("FAIL basic_wait got v=%0b busy=%0b rdy=%0b want 0 1 0", m_axis_tvalid, busy, cmd_tready);
        end
        recv_frame(1'b0, 50);
        total++;
        if (got_first_c !== 0) begin
            bad++;
            $display("FAIL basic_latency got %0d want 0", got_first_c);
        end
        check_pattern("basic", 32'h10, 4);
        total++;
        if (got_last_c !== 3) begin
            bad++;
            $display("FAIL basic_throughput got %0d want 3", got_last_c);
        end
        exp_cnt++;
        check_idle_after("basic");
    endtask

    task automatic test_almost_full_gate();
        fifo_almost_full = 1'b1;
        m_axis_tready = 1'b0;
        send_cmd(12'd1, 32'h55);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL af_hold[%0d] got v=%0b busy=%0b want 0 1", i, m_axis_tvalid, busy);
            end
        end
        fifo_almost_full = 1'b0;
        @(negedge clk);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h55) begin
            bad++;
            $display("FAIL af_release got v=%0b d=%h want 1 00000055", m_axis_tvalid, m_axis_tdata);
        end
        recv_frame(1'b0, 50);
        check_pattern("af", 32'h55, 2);
        exp_cnt++;
        check_idle_after("af");
    endtask

    task automatic test_random_tready();
        send_cmd(12'd255, 32'hA000_0000);
        recv_frame(1'b1, 3000);
        check_pattern("rand", 32'hA000_0000, 256);
        total++;
        if (got_unstable !== 0) begin
            bad++;
            $display("FAIL rand_stable got %0d want 0", got_unstable);
        end
        exp_cnt++;
        check_idle_after("rand");
    endtask

    task automatic test_wrap_and_single();
        send_cmd(12'd2, 32'hFFFF_FFFE);
        recv_frame(1'b0, 50);
        check_pattern("wrap", 32'hFFFF_FFFE, 3);
        exp_cnt++;
        check_idle_after("wrap");
        send_cmd(12'd0, 32'h1234);
        recv_frame(1'b0, 50);
        check_pattern("single", 32'h1234, 1);
        exp_cnt++;
        check_idle_after("single");
    endtask

    task automatic test_back_to_back();
        send_cmd(12'd1, 32'h40);
        cmd_tvalid = 1'b1;
        cmd_tdata  = {12'd0, 32'h80};
        recv_frame(1'b0, 50);
        check_pattern("b2b_first", 32'h40, 2);
        exp_cnt++;
        @(negedge clk);
        total++;
        if (cmd_tready !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL b2b_not_accepted got rdy=%0b busy=%0b cnt=%0d want 1 0 %0d",
                     cmd_tready, busy, frame_cnt, exp_cnt);
        end
        @(negedge clk);
        cmd_tvalid = 1'b0;
        total++;
        if (cmd_tready !== 1'b0 || busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept got rdy=%0b busy=%0b v=%0b want 0 1 0", cmd_tready, busy, m_axis_tvalid);
        end
        recv_frame(1'b0, 50);
        total++;
        if (got_first_c !== 0) begin
            bad++;
            $display("FAIL b2b_gap got %0d want 0", got_first_c);
        end
        check_pattern("b2b_second", 32'h80, 1);
        exp_cnt++;
        check_idle_after("b2b");
    endtask

    task automatic test_midframe_af();
        bool_found: begin end
        send_cmd(12'd7, 32'h700);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tdata == 32'h703) break;
        end
        total++;
        if (m_axis_tdata !== 32'h703) begin
            bad++;
            $display("FAIL midaf_word3 got %h want 00000703", m_axis_tdata);
        end
        fifo_almost_full = 1'b1;
`ifdef AXI_FRAME_TX_MIDFRAME_THROTTLE_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (m_axis_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL midaf_throttle[%0d] got v=%0b want 0", i, m_axis_tvalid);
            end
        end
        fifo_almost_full = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
`else
        @(negedge clk);
        m_axis_tready = 1'b0;
        fifo_almost_full = 1'b0;
`endif
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h704) begin
            bad++;
            $display("FAIL midaf_word4 got v=%0b d=%h want 1 00000704", m_axis_tvalid, m_axis_tdata);
        end
        recv_frame(1'b0, 50);
        check_pattern("midaf", 32'h704, 4);
        exp_cnt++;
        check_idle_after("midaf");
    endtask

    task automatic test_reset_midframe();
        send_cmd(12'd9, 32'h200);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tdata == 32'h205) break;
        end
        async_reset_n = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || frame_cnt !== 16'd0 || busy !== 1'b0 || cmd_tready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear got v=%0b cnt=%0d busy=%0b rdy=%0b want 0 0 0 0",
                     m_axis_tvalid, frame_cnt, busy, cmd_tready);
        end
        @(negedge clk);
        async_reset_n = 1'b1;
        exp_cnt = 16'd0;
        send_cmd(12'd9, 32'h300);
        recv_frame(1'b0, 50);
        check_pattern("rstmid", 32'h300, 10);
        exp_cnt++;
        check_idle_after("rstmid");
    endtask

    initial begin
        async_reset_n    = 1'b0;
        cmd_tvalid       = 1'b0;
        cmd_tdata        = '0;
        fifo_almost_full = 1'b0;
        m_axis_tready    = 1'b1;
        test_reset();
        test_basic_frame();
        test_almost_full_gate();
        test_random_tready();
        test_wrap_and_single();
        test_back_to_back();
        test_midframe_af();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
